// File: rtl/depth_window_feeder.sv
// Walks a zero-padded 3x3 window over an SxS map, fetching four channel lanes per read word, and presents one bundle per (h,w,group).
// Each bundle costs 9 tap cycles plus 1 drain cycle. In PRESENT the bundle is held until win_ready, and no memory is read while it waits.
module depth_window_feeder #(
   parameter int DATA_WIDTH          = 8,
   parameter int KERNEL_SIZE         = 3,
   parameter int CHANNEL_PARALLELISM = 4,
   parameter int PADDING             = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [7:0]              input_size,
   input  logic [7:0]              channel,
   output logic                    mem_rd_en,
   output logic [15:0]             mem_addr,
   input  logic [DATA_WIDTH*4-1:0] mem_rd_data,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic [DATA_WIDTH*9-1:0] win_feature1,
   output logic [DATA_WIDTH*9-1:0] win_feature2,
   output logic [DATA_WIDTH*9-1:0] win_feature3,
   output logic [DATA_WIDTH*9-1:0] win_feature4,
   output logic [7:0]              win_channel_sel,
   output logic [7:0]              win_h,
   output logic [7:0]              win_w,
   output logic                    last_group,
   output logic                    busy,
   output logic                    done
);

   localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
   localparam int LANES = CHANNEL_PARALLELISM;
   localparam int WIN_W = DATA_WIDTH * TAPS;
   localparam logic signed [10:0] PAD_S = 11'(PADDING);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PRESENT} state_t;

   state_t           state_q, state_d;
   logic [3:0]       tap_q, tap_d;
   logic [7:0]       h_q, h_d, w_q, w_d, s_q, s_d, c_q, c_d;
   logic [5:0]       g_q, g_d, g_last_q, g_last_d;
   logic             rd_pend_q, rd_pend_d;
   logic [3:0]       rd_tap_q, rd_tap_d;
   logic             done_q, done_d;
   logic [WIN_W-1:0] win_q [LANES];
   logic [WIN_W-1:0] win_d [LANES];

   logic [1:0]        tap_i, tap_j;
   logic signed [10:0] r_s, c_s;
   logic              tap_in_range;
   logic [LANES-1:0]  lane_act;
   logic              pass_end;

   // Tap geometry: row/col of the current tap relative to the padded border.
   always_comb begin
      tap_i = (tap_q >= 4'd6) ? 2'd2 : ((tap_q >= 4'd3) ? 2'd1 : 2'd0);
      tap_j = 2'(tap_q - 4'(tap_i) * 4'd3);
      r_s   = $signed({3'b000, h_q}) + $signed({9'd0, tap_i}) - PAD_S;
      c_s   = $signed({3'b000, w_q}) + $signed({9'd0, tap_j}) - PAD_S;
      tap_in_range = !r_s[10] && (r_s < $signed({3'b000, s_q})) &&
                     !c_s[10] && (c_s < $signed({3'b000, s_q}));
      for (int n = 0; n < LANES; n++) begin
         lane_act[n] = ({2'b00, g_q, 2'b00} + 10'(n)) < {2'b00, c_q};
      end
   end

   always_comb begin
      mem_rd_en = (state_q == FETCH) && tap_in_range;
      mem_addr  = '0;
      if (mem_rd_en) begin
         mem_addr = 16'(g_q) * 16'(s_q) * 16'(s_q) + 16'(r_s[7:0]) * 16'(s_q) + 16'(c_s[7:0]);
      end
   end

   always_comb begin
      state_d   = state_q;
      tap_d     = tap_q;
      h_d       = h_q;
      w_d       = w_q;
      g_d       = g_q;
      s_d       = s_q;
      c_d       = c_q;
      g_last_d  = g_last_q;
      rd_pend_d = 1'b0;
      rd_tap_d  = tap_q;
      done_d    = 1'b0;
      pass_end  = 1'b0;
      win_d     = win_q;

      // Read data lands one cycle after the strobe; store it into the slot of the tap that issued it.
      if (rd_pend_q) begin
         for (int n = 0; n < LANES; n++) begin
            win_d[n][DATA_WIDTH*rd_tap_q +: DATA_WIDTH] =
               lane_act[n] ? mem_rd_data[DATA_WIDTH*n +: DATA_WIDTH] : '0;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (channel == 8'd0 || input_size == 8'd0) begin
                  done_d = 1'b1;
               end else begin
                  s_d      = input_size;
                  c_d      = channel;
                  g_last_d = 6'(((9'(channel) + 9'd3) >> 2) - 9'd1);
                  h_d      = '0;
                  w_d      = '0;
                  g_d      = '0;
                  tap_d    = '0;
                  state_d  = FETCH;
               end
            end
         end
         FETCH: begin
            rd_pend_d = tap_in_range;
            rd_tap_d  = tap_q;
            if (!tap_in_range) begin
               for (int n = 0; n < LANES; n++) begin
                  win_d[n][DATA_WIDTH*tap_q +: DATA_WIDTH] = '0;
               end
            end
            if (tap_q == 4'(TAPS - 1)) begin
               tap_d   = '0;
               state_d = DRAIN;
            end else begin
               tap_d = tap_q + 4'd1;
            end
         end
         DRAIN: begin
            state_d = PRESENT;
         end
         PRESENT: begin
            if (win_ready) begin
               if (g_q != g_last_q) begin
                  g_d = g_q + 6'd1;
               end else begin
                  g_d = '0;
                  if (w_q != s_q - 8'd1) begin
                     w_d = w_q + 8'd1;
                  end else begin
                     w_d = '0;
                     if (h_q != s_q - 8'd1) begin
                        h_d = h_q + 8'd1;
                     end else begin
                        h_d      = '0;
                        pass_end = 1'b1;
                     end
                  end
               end
               if (pass_end) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tap_q     <= '0;
         h_q       <= '0;
         w_q       <= '0;
         g_q       <= '0;
         s_q       <= '0;
         c_q       <= '0;
         g_last_q  <= '0;
         rd_pend_q <= 1'b0;
         rd_tap_q  <= '0;
         done_q    <= 1'b0;
         for (int n = 0; n < LANES; n++) win_q[n] <= '0;
      end else begin
         state_q   <= state_d;
         tap_q     <= tap_d;
         h_q       <= h_d;
         w_q       <= w_d;
         g_q       <= g_d;
         s_q       <= s_d;
         c_q       <= c_d;
         g_last_q  <= g_last_d;
         rd_pend_q <= rd_pend_d;
         rd_tap_q  <= rd_tap_d;
         done_q    <= done_d;
         for (int n = 0; n < LANES; n++) win_q[n] <= win_d[n];
      end
   end

   assign win_valid       = (state_q == PRESENT);
   assign win_feature1    = win_q[0];
   assign win_feature2    = win_q[1];
   assign win_feature3    = win_q[2];
   assign win_feature4    = win_q[3];
   assign win_channel_sel = {g_q, 2'b00};
   assign win_h           = h_q;
   assign win_w           = w_q;
   assign last_group      = win_valid && (g_q == g_last_q);
   assign busy            = (state_q != IDLE);
   assign done            = done_q;

endmodule
